// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, master indices and
// system bus widths (8-bit address, 32-bit data).
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/bus_arbiter_rr_tenure_cnt.sv
// arb_tenure_cnt: saturating tenure counter with clear, enable and a
// terminal flag raised when the count sits at MAX_BURST-1.
// Ports: clk, reset (sync, active-high), i_clr, i_en -> o_cnt, o_term.
import bus_pkg::*;

module arb_tenure_cnt #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin bus arbiter with a guaranteed
// idle cycle between tenures. Define BUS_ARB_BURST_LIMIT_EN to force a
// release after MAX_BURST cycles when the other master is waiting.
// Ports: clk, reset (sync, active-high), M0_req, M1_req ->
//        M0_grant, M1_grant, M_sel, bus_busy, tenure_cnt.
import bus_pkg::*;

module bus_arbiter_rr #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M0_req,
    input  logic             M1_req,
    output logic             M0_grant,
    output logic             M1_grant,
    output logic             M_sel,
    output logic             bus_busy,
    output logic [CNT_W-1:0] tenure_cnt
);

    if (MAX_BURST < 2 || MAX_BURST > (1 << CNT_W)) begin : g_bad_cfg
        $error("bus_arbiter_rr: MAX_BURST out of range for CNT_W");
    end

    state_t r_state;
    logic   r_last;
    logic   r_sel;
    logic   r_g0;
    logic   r_g1;

    logic   w_in_grant;
    logic   w_own_req;
    logic   w_limit;
    logic   w_stay;
    logic   w_any_req;
    logic   w_win;

    assign w_in_grant = (r_state != ST_IDLE);
    assign w_own_req  = (r_state == ST_GRANT1) ? M1_req : M0_req;
    assign w_stay     = w_in_grant & w_own_req & ~w_limit;

    // Contention goes to the master that was not granted last
    assign w_any_req  = M0_req | M1_req;
    assign w_win      = (M0_req & M1_req) ? ~r_last : M1_req;

`ifdef BUS_ARB_BURST_LIMIT_EN
    logic             w_oth_req;
    logic             w_term;
    logic [CNT_W-1:0] w_cnt;

    assign w_oth_req = (r_state == ST_GRANT1) ? M0_req : M1_req;
    assign w_limit   = w_term & w_oth_req;

    // Cleared on every edge that does not extend the tenure, so it
    // reads 0 in IDLE and in the first granted cycle
    arb_tenure_cnt #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (~w_stay),
        .i_en   (w_stay),
        .o_cnt  (w_cnt),
        .o_term (w_term)
    );

    assign tenure_cnt = w_cnt;
`else
    assign w_limit    = 1'b0;
    assign tenure_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= MST_M1;
            r_sel   <= MST_M0;
            r_g0    <= 1'b0;
            r_g1    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= w_win ? ST_GRANT1 : ST_GRANT0;
                        r_last  <= w_win;
                        r_sel   <= w_win;
                        r_g0    <= ~w_win;
                        r_g1    <= w_win;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (!w_stay) begin
                        r_state <= ST_IDLE;
                        r_g0    <= 1'b0;
                        r_g1    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_g0    <= 1'b0;
                    r_g1    <= 1'b0;
                end
            endcase
        end
    end

    assign M0_grant = r_g0;
    assign M1_grant = r_g1;
    assign M_sel    = r_sel;
    assign bus_busy = r_g0 | r_g1;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: tenure-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_bus_arbiter_rr;

    localparam int MAXB = 8;
    localparam int CW   = 4;
`ifdef BUS_ARB_BURST_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          M0_req = 1'b0;
    logic          M1_req = 1'b0;
    logic          M0_grant;
    logic          M1_grant;
    logic          M_sel;
    logic          bus_busy;
    logic [CW-1:0] tenure_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter_rr #(.MAX_BURST(MAXB), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M1_req     (M1_req),
        .M0_grant   (M0_grant),
        .M1_grant   (M1_grant),
        .M_sel      (M_sel),
        .bus_busy   (bus_busy),
        .tenure_cnt (tenure_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: owner (-1 = none) and number of granted cycles
    int  m_own   = -1;
    int  m_last  = 1;
    int  m_sel   = 0;
    int  m_len   = 0;
    bit  m_valid = 1'b0;

    always @(posedge clk) begin
        int own_r;
        int oth_r;
        if (reset) begin
            m_own   = -1;
            m_last  = 1;
            m_sel   = 0;
            m_len   = 0;
            m_valid = 1'b1;
        end else if (m_own < 0) begin
            if (M0_req || M1_req) begin
                if (M0_req && M1_req) m_own = 1 - m_last;
                else                  m_own = M1_req ? 1 : 0;
                m_last = m_own;
                m_sel  = m_own;
                m_len  = 1;
            end
        end else begin
            own_r = (m_own == 1) ? int'(M1_req) : int'(M0_req);
            oth_r = (m_own == 1) ? int'(M0_req) : int'(M1_req);
            if (own_r == 0 || (LIM_EN && m_len >= MAXB && oth_r != 0)) begin
                m_own = -1;
                m_len = 0;
            end else begin
                m_len++;
            end
        end
    end

    always @(negedge clk) begin
        int ecnt;
        if (m_valid) begin
            ecnt = 0;
            if (LIM_EN && m_own >= 0)
                ecnt = (m_len - 1 < MAXB - 1) ? m_len - 1 : MAXB - 1;
            chk("model_g0",   int'(M0_grant), int'(m_own == 0));
            chk("model_g1",   int'(M1_grant), int'(m_own == 1));
            chk("model_busy", int'(bus_busy), int'(m_own >= 0));
            chk("model_sel",  int'(M_sel),    m_sel);
            chk("model_cnt",  int'(tenure_cnt), ecnt);
            chk("mutex",      int'(M0_grant & M1_grant), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int g0_cycles;
        int ph;
        int e0;
        int e1;
        int ec;

        // Reset with both requests high
        @(negedge clk);
        reset  = 1'b1;
        M0_req = 1'b1;
        M1_req = 1'b1;
        tick(2);
        chk("rst_g0",   int'(M0_grant), 0);
        chk("rst_g1",   int'(M1_grant), 0);
        chk("rst_sel",  int'(M_sel), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_cnt",  int'(tenure_cnt), 0);
        reset = 1'b0;
        tick(1);
        chk("first_g0",  int'(M0_grant), 1);
        chk("first_sel", int'(M_sel), 0);
        M0_req = 1'b0;
        M1_req = 1'b0;
        tick(2);
        chk("idle_busy", int'(bus_busy), 0);

        // M0 alone for 5 cycles
        M0_req = 1'b1;
        g0_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (M0_grant) g0_cycles++;
            chk("burst5_cnt", int'(tenure_cnt), LIM_EN ? i : 0);
        end
        M0_req = 1'b0;
        tick(1);
        chk("burst5_len",  g0_cycles, 5);
        chk("burst5_drop", int'(M0_grant), 0);
        tick(1);

        // Fresh pointer, then two back-to-back contentions
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        M0_req = 1'b1;
        M1_req = 1'b1;
        tick(1);
        chk("rr1_g0", int'(M0_grant), 1);
        tick(2);
        M0_req = 1'b0;
        M1_req = 1'b0;
        tick(1);
        chk("rr1_idle", int'(bus_busy), 0);
        M0_req = 1'b1;
        M1_req = 1'b1;
        tick(1);
        chk("rr2_g1",  int'(M1_grant), 1);
        chk("rr2_sel", int'(M_sel), 1);
        tick(2);
        M0_req = 1'b0;
        M1_req = 1'b0;
        tick(2);

        // Handover: M0 owns, M1 waits, M0 releases 4 cycles later
        M0_req = 1'b1;
        tick(1);
        chk("ho_g0", int'(M0_grant), 1);
        M1_req = 1'b1;
        tick(4);
        chk("ho_hold", int'(M0_grant), 1);
        M0_req = 1'b0;
        tick(1);
        chk("ho_gap_busy", int'(bus_busy), 0);
        chk("ho_gap_sel",  int'(M_sel), 0);
        tick(1);
        chk("ho_g1",  int'(M1_grant), 1);
        chk("ho_sel", int'(M_sel), 1);
        M1_req = 1'b0;
        tick(2);

        // Both held: forced rotation with the limit, M0 forever without
        M0_req = 1'b1;
        M1_req = 1'b1;
        for (int t = 0; t < 36; t++) begin
            tick(1);
            if (LIM_EN) begin
                ph = t % 18;
                e0 = int'(ph < 8);
                e1 = int'(ph >= 9 && ph < 17);
                ec = (e0 != 0) ? ph : ((e1 != 0) ? ph - 9 : 0);
            end else begin
                e0 = 1;
                e1 = 0;
                ec = 0;
            end
            chk("hold_g0",  int'(M0_grant), e0);
            chk("hold_g1",  int'(M1_grant), e1);
            chk("hold_cnt", int'(tenure_cnt), ec);
        end
        M0_req = 1'b0;
        M1_req = 1'b0;
        tick(2);

        // Reset during a GRANT1 tenure
        M1_req = 1'b1;
        tick(2);
        chk("pre_rst_g1", int'(M1_grant), 1);
        reset  = 1'b1;
        M0_req = 1'b1;
        tick(1);
        chk("mid_rst_g1",  int'(M1_grant), 0);
        chk("mid_rst_sel", int'(M_sel), 0);
        chk("mid_rst_cnt", int'(tenure_cnt), 0);
        reset = 1'b0;
        tick(1);
        chk("post_rst_g0", int'(M0_grant), 1);
        M0_req = 1'b0;
        M1_req = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Two-master round-robin arbiter that owns the grant logic for the shared 8-bit-address / 32-bit-data system bus. It sits between masters M0/M1 and the bus datapath mux. It issues `M0_grant`/`M1_grant` and the mux select `M_sel`. It guarantees one idle cycle between tenures and, optionally, a bounded tenure length so that neither master can starve the other.

## Interface
- `MAX_BURST`, default 8: maximum grant cycles per tenure while the other master is waiting; legal range 2..2^CNT_W.
- `CNT_W`, default 4: tenure counter width.
- `clk`  in  1  bus clock; all state changes on the rising edge.
- `reset`  in  1  reset is synchronous and active-high; one clock; sampled on rising `clk`.
- `M0_req`  in  1  master 0 request; held high for the whole transfer sequence.
- `M1_req`  in  1  master 1 request.
- `M0_grant`  out  1  master 0 owns the bus.
- `M1_grant`  out  1  master 1 owns the bus.
- `M_sel`  out  1  datapath mux select: 0 = M0, 1 = M1; holds the last owner.
- `bus_busy`  out  1  `M0_grant | M1_grant`.
- `tenure_cnt`  out  CNT_W  cycles elapsed in the current tenure; 0 when idle.

## Operation
- States are `IDLE`, `GRANT0` and `GRANT1`. All outputs are registered.
- Priority pointer `last`: 1 bit holding the most recently granted master. Reset value is 1, so M0 wins the first contention.
- `IDLE`:
  - Only `M0_req` high → `GRANT0`.
  - Only `M1_req` high → `GRANT1`.
  - Both high → grant `~last`.
  - Neither high → stay in `IDLE`.
  - On entering `GRANTx`: `last` ← x, `M_sel` ← x, `tenure_cnt` ← 0.
- `GRANTx`, with `Mx_req` high:
  - Stay in `GRANTx`.
  - `tenure_cnt` increments and saturates at `MAX_BURST-1`.
- `GRANTx`, with `Mx_req` low:
  - Next state is `IDLE`; the grant drops at that edge.
  - The other master is evaluated in `IDLE`, so there is always at least one grant-free cycle between owners.
- Grant deassertion ends ownership. The arbiter never revokes a grant, except under the forced release configured in ## Configuration.
- Invariants:
  - `M0_grant & M1_grant` is never 1.
  - `M_sel` changes only on the edge that raises a grant.
- Simultaneous events:
  - Owner drops its request in the same cycle the other master raises its request → `IDLE`, then grant to the other master.
  - Request glitch in `IDLE` shorter than one cycle between edges → ignored.
- Reset mid-tenure: at the next edge the state is `IDLE`, the grants drop, `M_sel`=0, `last`=1 and `tenure_cnt`=0. Masters must treat the loss of grant as an abort.

## Timing
- Reset values:
  - `M0_grant`=0
  - `M1_grant`=0
  - `M_sel`=0
  - `bus_busy`=0
  - `tenure_cnt`=0
- Grant latency: a request sampled high at edge k in `IDLE` produces its grant visible after edge k. This is 1 cycle from the request being seen.
- Release latency: request sampled low at edge k → grant low after edge k.
- Handover: owner request low at edge k → idle cycle → other master granted after edge k+1. Minimum owner-to-owner gap is 1 cycle.
- `tenure_cnt` reads 0 in the first granted cycle and n in the (n+1)-th granted cycle.

## Configuration
- `BUS_ARB_BURST_LIMIT_EN` defined:
  - In `GRANTx`, if `tenure_cnt == MAX_BURST-1` and the other master's request is high, the next state is `IDLE` (forced release).
  - `last`=x then guarantees the other master wins the next contention.
  - If the other master is not requesting, the grant continues and the counter stays saturated.
- `BUS_ARB_BURST_LIMIT_EN` undefined:
  - No forced release; a tenure lasts as long as the request stays high.
  - The counter logic is not compiled; `tenure_cnt` is tied to 0.

## Structure
- Shared package `bus_pkg`:
  - State encoding constants `ST_IDLE`, `ST_GRANT0`, `ST_GRANT1`.
  - Master index constants `MST_M0`=0 and `MST_M1`=1.
  - Bus widths: address 8, data 32.
- One sub-module, `arb_tenure_cnt`: a saturating counter with clear, enable and terminal flag. It is instantiated only under `BUS_ARB_BURST_LIMIT_EN`.
- The FSM and priority pointer live in `bus_arbiter_rr`.

## Test plan
- Reset held 2 cycles with both requests high → all outputs 0. After release, `M0_grant`=1 one edge later and `M_sel`=0.
- `M0_req` high for 5 cycles then low, `M1_req` low → `M0_grant` high for exactly 5 cycles, `tenure_cnt` counts 0..4, then `IDLE`.
- Both requests high from `IDLE` twice in a row, each request dropped after 3 cycles of grant → first grant goes to M0, second to M1.
- M0 owns the bus, `M1_req` rises, and M0 drops its request 4 cycles later → M0 grant falls, one cycle with `bus_busy`=0, then `M1_grant`=1 and `M_sel`=1.
- With `BUS_ARB_BURST_LIMIT_EN`, `MAX_BURST`=8, both requests held high → M0 granted for 8 cycles, 1 idle cycle, M1 granted for 8 cycles, repeating. Without the macro → M0 is held indefinitely and `tenure_cnt`=0.
- Reset asserted during `GRANT1` → `M1_grant`=0 and `M_sel`=0 at the next edge. After release with both requests high, M0 is granted.
